// File: rtl/serial_rx_framer.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling, 8N1 deframing with one-cycle strobes.
// Define SERIAL_RX_PARITY_EN for 8E1 frames with a parity_err strobe.
`timescale 1ns/1ps
module serial_rx_framer #(
   parameter int unsigned CLK_PER_BIT = 50,
   parameter int unsigned CTR_SIZE    = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       new_data,
   output logic       frame_err,
   output logic       parity_err
);

   localparam int unsigned DATA_W = 8;
   localparam int unsigned IDX_W  = 3;
   localparam logic [CTR_SIZE-1:0] HALF_LAST = CTR_SIZE'(CLK_PER_BIT / 2 - 1);
   localparam logic [CTR_SIZE-1:0] BIT_LAST  = CTR_SIZE'(CLK_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
   } state_t;

   state_t              state, state_nxt;
   logic                rx_m, rx_s;
   logic [CTR_SIZE-1:0] ctr, ctr_nxt;
   logic [IDX_W-1:0]    bit_ctr, bit_ctr_nxt;
   logic [DATA_W-1:0]   shift, shift_nxt;
   logic [DATA_W-1:0]   data_nxt;
   logic                new_data_nxt, frame_err_nxt;
   logic                half_hit, bit_hit;

   assign half_hit = (ctr == HALF_LAST);
   assign bit_hit  = (ctr == BIT_LAST);

   // Synchroniser resets to the idle-line level so reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (!rx_s) state_nxt = S_START;
         S_START: if (half_hit) state_nxt = rx_s ? S_IDLE : S_DATA;
         S_DATA: begin
            if (bit_hit && (bit_ctr == IDX_W'(DATA_W - 1))) begin
`ifdef SERIAL_RX_PARITY_EN
               state_nxt = S_PARITY;
`else
               state_nxt = S_STOP;
`endif
            end
         end
`ifdef SERIAL_RX_PARITY_EN
         S_PARITY: if (bit_hit) state_nxt = S_STOP;
`endif
         S_STOP:  if (bit_hit) state_nxt = rx_s ? S_IDLE : S_BREAK;
         S_BREAK: if (rx_s) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

`ifdef SERIAL_RX_PARITY_EN
   logic par_pend, par_pend_nxt;
   logic parity_err_nxt;
`endif

   // Bit-time counting, shifting and strobe generation.
   always_comb begin
      ctr_nxt       = ctr;
      bit_ctr_nxt   = bit_ctr;
      shift_nxt     = shift;
      data_nxt      = data;
      new_data_nxt  = 1'b0;
      frame_err_nxt = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_pend_nxt   = par_pend;
      parity_err_nxt = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            ctr_nxt     = '0;
            bit_ctr_nxt = '0;
`ifdef SERIAL_RX_PARITY_EN
            par_pend_nxt = 1'b0;
`endif
         end
         S_START: begin
            ctr_nxt     = half_hit ? '0 : ctr + CTR_SIZE'(1);
            bit_ctr_nxt = '0;
         end
         S_DATA: begin
            if (bit_hit) begin
               ctr_nxt            = '0;
               shift_nxt[bit_ctr] = rx_s;
               bit_ctr_nxt        = bit_ctr + IDX_W'(1);
            end else begin
               ctr_nxt = ctr + CTR_SIZE'(1);
            end
         end
`ifdef SERIAL_RX_PARITY_EN
         S_PARITY: begin
            if (bit_hit) begin
               ctr_nxt      = '0;
               par_pend_nxt = (rx_s != ^shift);
            end else begin
               ctr_nxt = ctr + CTR_SIZE'(1);
            end
         end
`endif
         S_STOP: begin
            if (bit_hit) begin
               ctr_nxt = '0;
               if (rx_s) begin
`ifdef SERIAL_RX_PARITY_EN
                  if (par_pend) begin
                     parity_err_nxt = 1'b1;
                  end else begin
                     data_nxt     = shift;
                     new_data_nxt = 1'b1;
                  end
`else
                  data_nxt     = shift;
                  new_data_nxt = 1'b1;
`endif
               end else begin
                  frame_err_nxt = 1'b1;
               end
            end else begin
               ctr_nxt = ctr + CTR_SIZE'(1);
            end
         end
         default: ctr_nxt = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctr       <= '0;
         bit_ctr   <= '0;
         shift     <= '0;
         data      <= '0;
         new_data  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         ctr       <= ctr_nxt;
         bit_ctr   <= bit_ctr_nxt;
         shift     <= shift_nxt;
         data      <= data_nxt;
         new_data  <= new_data_nxt;
         frame_err <= frame_err_nxt;
      end
   end

`ifdef SERIAL_RX_PARITY_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         par_pend   <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         par_pend   <= par_pend_nxt;
         parity_err <= parity_err_nxt;
      end
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_rx_framer.sv
// Bench for serial_rx_framer: directed frames plus random traffic against a frame-level event model.
`timescale 1ns/1ps
module tb_serial_rx_framer;

   localparam int unsigned CPB   = 16;
   localparam int unsigned CTR_W = 5;
   localparam time         HALF  = 5;
   localparam time         PER   = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx  = 1'b1;
   logic [7:0] data;
   logic       new_data, frame_err, parity_err;

   int total = 0;
   int bad   = 0;

   // Expected strobe per frame: kind 1 = new_data, 2 = frame_err, 3 = parity_err.
   typedef struct {
      int         kind;
      logic [7:0] data;
   } ev_t;
   ev_t        exp_q[$];
   logic [7:0] last_good = 8'h00;
   time        nd_t = 0;
   logic       prev_any = 1'b0;

   serial_rx_framer #(.CLK_PER_BIT(CPB), .CTR_SIZE(CTR_W)) dut (
      .clk(clk), .rst(rst), .rx(rx), .data(data),
      .new_data(new_data), .frame_err(frame_err), .parity_err(parity_err)
   );

   always #(HALF) clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Every strobe is matched in order against the model's expected events.
   always @(negedge clk) begin
      int  n;
      int  kind;
      ev_t e;
      n = int'(new_data) + int'(frame_err) + int'(parity_err);
      if (n != 0) begin
         check("one_hot", 32'(n), 32'd1);
         check("single_cycle", 32'(prev_any), 32'd0);
         kind = new_data ? 1 : (frame_err ? 2 : 3);
         if (new_data) nd_t = $time - HALF;
         if (exp_q.size() == 0) begin
            check("unexpected_strobe", 32'(kind), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("strobe_kind", 32'(kind), 32'(e.kind));
            check("strobe_data", 32'(data), 32'(e.data));
         end
      end
      prev_any = (n != 0);
   end

   task automatic drive_bit(input logic v);
      rx = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_ok);
      ev_t e;
      if (!stop)       e.kind = 2;
      else if (!par_ok) e.kind = 3;
      else begin
         e.kind    = 1;
         last_good = b;
      end
      e.data = last_good;
      exp_q.push_back(e);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef SERIAL_RX_PARITY_EN
      drive_bit((^b) ^ ~par_ok);
`endif
      drive_bit(stop);
   endtask

   initial begin
      time        fall_t;
      int         lat;
      logic [7:0] b;
      logic       stop;
      logic       par_ok;
      int         gap;

      rst = 1'b0;
      rx  = 1'b1;
      repeat (5) @(negedge clk);
      check("rst_data", 32'(data), 32'h00);
      check("rst_new_data", 32'(new_data), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      check("rst_parity_err", 32'(parity_err), 32'd0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_data", 32'(data), 32'h00);
      check("idle_new_data", 32'(new_data), 32'd0);

      // Single frame with latency measurement from rx fall to new_data rising edge.
      fall_t = $time;
      send_frame(8'h31, 1'b1, 1'b1);
      lat = int'((nd_t - fall_t) / PER);
`ifdef SERIAL_RX_PARITY_EN
      check("latency_window", 32'(lat >= 169 && lat <= 171), 32'd1);
`else
      check("latency_window", 32'(lat >= 153 && lat <= 155), 32'd1);
`endif
      check("q_empty_31", 32'(exp_q.size()), 32'd0);
      check("data_31", 32'(data), 32'h31);

      send_frame(8'h30, 1'b1, 1'b1);
      check("b2b_first", 32'(data), 32'h30);
      send_frame(8'h31, 1'b1, 1'b1);
      check("b2b_second", 32'(data), 32'h31);
      check("q_empty_b2b", 32'(exp_q.size()), 32'd0);

      // Short low pulse must be rejected as a glitch.
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      check("glitch_data", 32'(data), 32'h31);
      send_frame(8'hA5, 1'b1, 1'b1);
      check("after_glitch", 32'(data), 32'hA5);

      // Stop bit low then line held low: one frame_err only.
      send_frame(8'h55, 1'b0, 1'b1);
      repeat (40) @(negedge clk);
      drive_bit(1'b1);
      check("break_q_empty", 32'(exp_q.size()), 32'd0);
      check("break_data", 32'(data), 32'hA5);
      send_frame(8'h30, 1'b1, 1'b1);
      check("after_break", 32'(data), 32'h30);

`ifdef SERIAL_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b1);
      check("par_good", 32'(data), 32'h07);
      send_frame(8'h07, 1'b1, 1'b0);
      check("par_bad_q", 32'(exp_q.size()), 32'd0);
      check("par_bad_data", 32'(data), 32'h07);
`endif

      // Reset in the middle of the data bits discards the frame.
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      drive_bit(1'b1);
      rst = 1'b0;
      rx  = 1'b1;
      last_good = 8'h00;
      @(negedge clk);
      check("midrst_data", 32'(data), 32'h00);
      check("midrst_strobes", 32'({new_data, frame_err, parity_err}), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      check("midrst_idle", 32'(data), 32'h00);
      send_frame(8'h5A, 1'b1, 1'b1);
      check("after_midrst", 32'(data), 32'h5A);

      // Random traffic: random bytes, occasional framing/parity errors, gaps of 0-3 bits.
      for (int k = 0; k < 40; k++) begin
         b    = 8'($urandom);
         stop = ($urandom_range(0, 5) != 0);
`ifdef SERIAL_RX_PARITY_EN
         par_ok = ($urandom_range(0, 4) != 0);
`else
         par_ok = 1'b1;
`endif
         gap = int'($urandom_range(0, 3));
         send_frame(b, stop, par_ok);
         if (!stop) begin
            repeat ($urandom_range(0, 30)) @(negedge clk);
            drive_bit(1'b1);
         end
         for (int g = 0; g < gap; g++) drive_bit(1'b1);
         check("rand_frame_done", 32'(exp_q.size()), 32'd0);
      end
      check("rand_final_data", 32'(data), 32'(last_good));

      repeat (3 * CPB) @(negedge clk);
      check("no_leftover", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
